// File: rtl/msj_pid_pkg.sv
// rtl/msj_pid_pkg.sv - shared types, config address map and saturation helper for the PID controller
//
// Contents:
//   control_mode_e  per-channel control mode
//   CFG_*           config port address map
//   state_e         sweep sequencer states
//   sat()           saturate a wide signed value to a given signed width
package msj_pid_pkg;

  typedef enum logic [1:0] {
    MODE_POSITION = 2'b00,
    MODE_VELOCITY = 2'b01,
    MODE_DIRECT   = 2'b10,
    MODE_OFF      = 2'b11
  } control_mode_e;

  localparam logic [3:0] CFG_KP             = 4'd0;
  localparam logic [3:0] CFG_KI             = 4'd1;
  localparam logic [3:0] CFG_KD             = 4'd2;
  localparam logic [3:0] CFG_SP             = 4'd3;
  localparam logic [3:0] CFG_OUT_POS_MAX    = 4'd4;
  localparam logic [3:0] CFG_OUT_NEG_MAX    = 4'd5;
  localparam logic [3:0] CFG_INT_POS_MAX    = 4'd6;
  localparam logic [3:0] CFG_INT_NEG_MAX    = 4'd7;
  localparam logic [3:0] CFG_DEAD_BAND      = 4'd8;
  localparam logic [3:0] CFG_ZERO_SPEED     = 4'd9;
  localparam logic [3:0] CFG_CONTROL_MODE   = 4'd10;
  localparam logic [3:0] CFG_OUTPUT_DIVIDER = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ERR,
    ST_MUL_P,
    ST_MUL_I,
    ST_MUL_D,
    ST_OUT
  } state_e;

  // Wide enough for any accumulator of a DATA_W up to 60 bits.
  localparam int SAT_W = 128;

  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] value,
                                                   input int unsigned width);
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = SAT_W'(1);
    hi  = (one <<< (width - 1)) - one;
    lo  = -hi - one;
    if (value > hi) begin
      return hi;
    end
    if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/msj_pid_mul.sv
// rtl/msj_pid_mul.sv - registered signed multiplier shared by all PID terms
//
// Ports:
//   clock    in   system clock
//   reset    in   synchronous, active-high
//   a, b     in   signed OP_W operands
//   product  out  signed 2*OP_W product, one cycle after the operands
module msj_pid_mul #(
  parameter int OP_W = 33
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic signed [OP_W-1:0]   a,
  input  logic signed [OP_W-1:0]   b,
  output logic signed [2*OP_W-1:0] product
);

  always_ff @(posedge clock) begin
    if (reset) begin
      product <= '0;
    end else begin
      product <= (2*OP_W)'(a) * (2*OP_W)'(b);
    end
  end

endmodule

// File: rtl/msj_pid_controller_mc.sv
// rtl/msj_pid_controller_mc.sv - time-multiplexed multi-channel PID controller
//
// Ports:
//   clock              in   system clock
//   reset              in   synchronous, active-high
//   cfg_write          in   single-cycle config write strobe
//   cfg_channel        in   channel being configured (out-of-range ignored)
//   cfg_addr           in   config register select (see CFG_* in msj_pid_pkg)
//   cfg_writedata      in   value written
//   position           in   packed signed position feedback, channel i at [i*DATA_W +: DATA_W]
//   velocity           in   packed signed velocity feedback, same packing
//   update_controller  in   rising edge starts one sweep of all channels
//   duty               out  packed signed duty per channel
//   busy               out  high while a sweep runs
//   done               out  one-cycle pulse after the last channel is written
module msj_pid_controller_mc
  import msj_pid_pkg::*;
#(
  parameter  int NUM_CH = 6,
  parameter  int DATA_W = 32,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cfg_write,
  input  logic [CH_W-1:0]          cfg_channel,
  input  logic [3:0]               cfg_addr,
  input  logic [DATA_W-1:0]        cfg_writedata,
  input  logic [NUM_CH*DATA_W-1:0] position,
  input  logic [NUM_CH*DATA_W-1:0] velocity,
  input  logic                     update_controller,
  output logic [NUM_CH*DATA_W-1:0] duty,
  output logic                     busy,
  output logic                     done
);

  localparam int ACC_W  = 2*DATA_W + 4;
  localparam int OP_W   = DATA_W + 1;
  localparam int PROD_W = 2*OP_W;

  // Per-channel configuration
  logic signed [DATA_W-1:0] kp_q  [NUM_CH];
  logic signed [DATA_W-1:0] ki_q  [NUM_CH];
  logic signed [DATA_W-1:0] kd_q  [NUM_CH];
  logic signed [DATA_W-1:0] sp_q  [NUM_CH];
  logic signed [DATA_W-1:0] opm_q [NUM_CH];
  logic signed [DATA_W-1:0] onm_q [NUM_CH];
  logic signed [DATA_W-1:0] ipm_q [NUM_CH];
  logic signed [DATA_W-1:0] inm_q [NUM_CH];
  logic signed [DATA_W-1:0] db_q  [NUM_CH];
  logic signed [DATA_W-1:0] zs_q  [NUM_CH];
  control_mode_e            mode_q[NUM_CH];
  logic [5:0]               div_q [NUM_CH];

  // Per-channel controller state
  logic signed [DATA_W-1:0] integral_q [NUM_CH];
  logic signed [DATA_W-1:0] last_err_q [NUM_CH];
  logic signed [DATA_W-1:0] duty_q     [NUM_CH];
  control_mode_e            prev_mode_q[NUM_CH];

  logic signed [DATA_W-1:0] pos_arr[NUM_CH];
  logic signed [DATA_W-1:0] vel_arr[NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign pos_arr[g] = position[g*DATA_W +: DATA_W];
    assign vel_arr[g] = velocity[g*DATA_W +: DATA_W];
    assign duty[g*DATA_W +: DATA_W] = duty_q[g];
  end

  // ---------------------------------------------------------------
  // Config port
  // ---------------------------------------------------------------
  logic cfg_hit;
  assign cfg_hit = cfg_write && ({1'b0, cfg_channel} < (CH_W+1)'(NUM_CH));

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        kp_q[i]   <= '0;
        ki_q[i]   <= '0;
        kd_q[i]   <= '0;
        sp_q[i]   <= '0;
        opm_q[i]  <= '0;
        onm_q[i]  <= '0;
        ipm_q[i]  <= '0;
        inm_q[i]  <= '0;
        db_q[i]   <= '0;
        zs_q[i]   <= '0;
        mode_q[i] <= MODE_POSITION;
        div_q[i]  <= '0;
      end
    end else if (cfg_hit) begin
      case (cfg_addr)
        CFG_KP:             kp_q[cfg_channel]   <= cfg_writedata;
        CFG_KI:             ki_q[cfg_channel]   <= cfg_writedata;
        CFG_KD:             kd_q[cfg_channel]   <= cfg_writedata;
        CFG_SP:             sp_q[cfg_channel]   <= cfg_writedata;
        CFG_OUT_POS_MAX:    opm_q[cfg_channel]  <= cfg_writedata;
        CFG_OUT_NEG_MAX:    onm_q[cfg_channel]  <= cfg_writedata;
        CFG_INT_POS_MAX:    ipm_q[cfg_channel]  <= cfg_writedata;
        CFG_INT_NEG_MAX:    inm_q[cfg_channel]  <= cfg_writedata;
        CFG_DEAD_BAND:      db_q[cfg_channel]   <= cfg_writedata;
        CFG_ZERO_SPEED:     zs_q[cfg_channel]   <= cfg_writedata;
        CFG_CONTROL_MODE:   mode_q[cfg_channel] <= control_mode_e'(cfg_writedata[1:0]);
        CFG_OUTPUT_DIVIDER: div_q[cfg_channel]  <= cfg_writedata[5:0];
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Sweep sequencer
  // ---------------------------------------------------------------
  state_e          state_q, state_d;
  logic [CH_W-1:0] ch_q;
  logic            pending_q;
  logic            done_q;
  logic            upd_q1, upd_q2;
  logic            rise;
  logic            last_ch;

  assign rise    = upd_q1 & ~upd_q2;
  assign last_ch = (ch_q == CH_W'(NUM_CH - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      upd_q1    <= 1'b0;
      upd_q2    <= 1'b0;
    end else begin
      state_q <= state_d;
      upd_q1  <= update_controller;
      upd_q2  <= upd_q1;
      done_q  <= (state_q == ST_OUT) && last_ch;
      if (state_q == ST_IDLE) begin
        ch_q <= '0;
      end else if (state_q == ST_OUT && !last_ch) begin
        ch_q <= ch_q + CH_W'(1);
      end
      // Only one request can queue behind a running sweep; idle consumes it.
      if (state_q == ST_IDLE) begin
        pending_q <= 1'b0;
      end else if (rise) begin
        pending_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (rise || pending_q) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_ERR;
      ST_ERR:   state_d = ST_MUL_P;
      ST_MUL_P: state_d = ST_MUL_I;
      ST_MUL_I: state_d = ST_MUL_D;
      ST_MUL_D: state_d = ST_OUT;
      ST_OUT:   state_d = last_ch ? ST_IDLE : ST_LOAD;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Snapshot of the channel being processed
  logic signed [DATA_W-1:0] w_kp, w_ki, w_kd, w_sp, w_opm, w_onm, w_ipm, w_inm, w_db, w_zs;
  logic signed [DATA_W-1:0] w_fb, w_int, w_last, err_q;
  control_mode_e            w_mode;
  logic [5:0]               w_div;
  logic signed [PROD_W-1:0] pterm_q, iprod_q, product;
  logic signed [OP_W-1:0]   mul_a, mul_b, d_err;
  logic                     mul_enable;

  assign d_err      = OP_W'(err_q) - OP_W'(w_last);
  assign mul_enable = (w_mode == MODE_POSITION) || (w_mode == MODE_VELOCITY);

  always_comb begin
    busy  = (state_q != ST_IDLE);
    done  = done_q;
    mul_a = '0;
    mul_b = '0;
    if (mul_enable) begin
      case (state_q)
        ST_MUL_P: begin mul_a = OP_W'(w_kp); mul_b = OP_W'(err_q); end
        ST_MUL_I: begin mul_a = OP_W'(w_ki); mul_b = OP_W'(err_q); end
        ST_MUL_D: begin mul_a = OP_W'(w_kd); mul_b = d_err;        end
        default: ;
      endcase
    end
  end

  msj_pid_mul #(.OP_W(OP_W)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .a       (mul_a),
    .b       (mul_b),
    .product (product)
  );

  // ---------------------------------------------------------------
  // Error and output arithmetic
  // ---------------------------------------------------------------
  logic signed [OP_W-1:0]   diff, diff_sh;
  logic signed [ACC_W-1:0]  err_a, db_a, pterm_a, dterm_a, int_a, int_acc, int_next, result;
  logic                     in_db, windup_ok;
  logic signed [DATA_W-1:0] out_duty, out_int, out_last;

  assign diff    = OP_W'(w_sp) - OP_W'(w_fb);
  assign diff_sh = diff >>> w_div;

  // Lower bound first so the upper bound wins when the limits are misordered.
  function automatic logic signed [ACC_W-1:0] clamp_acc(input logic signed [ACC_W-1:0] v,
                                                         input logic signed [ACC_W-1:0] lo,
                                                         input logic signed [ACC_W-1:0] hi);
    logic signed [ACC_W-1:0] r;
    r = v;
    if (r < lo) r = lo;
    if (r > hi) r = hi;
    return r;
  endfunction

  always_comb begin
    err_a     = ACC_W'(err_q);
    db_a      = ACC_W'(w_db);
    pterm_a   = ACC_W'(pterm_q);
    dterm_a   = ACC_W'(product);
    int_a     = ACC_W'(w_int);
    in_db     = (err_a > -db_a) && (err_a < db_a);
    // Integrate only while the proportional term alone is inside the output range.
    windup_ok = (pterm_a > ACC_W'(w_onm)) && (pterm_a < ACC_W'(w_opm));
    int_acc   = clamp_acc(int_a + ACC_W'(iprod_q), ACC_W'(w_inm), ACC_W'(w_ipm));
    int_next  = windup_ok ? int_acc : int_a;
    result    = clamp_acc(ACC_W'(w_zs) + pterm_a + dterm_a + int_next, ACC_W'(w_onm), ACC_W'(w_opm));
    out_duty  = '0;
    out_int   = '0;
    out_last  = '0;
    case (w_mode)
      MODE_DIRECT: out_duty = w_sp;
      MODE_OFF:    out_duty = '0;
      default: begin
        out_last = err_q;
        if (in_db) begin
          out_duty = w_zs;
          out_int  = w_int;
        end else begin
          out_duty = DATA_W'(sat(SAT_W'(result), DATA_W));
          out_int  = DATA_W'(int_next);
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_kp    <= '0; w_ki  <= '0; w_kd  <= '0; w_sp  <= '0;
      w_opm   <= '0; w_onm <= '0; w_ipm <= '0; w_inm <= '0;
      w_db    <= '0; w_zs  <= '0; w_fb  <= '0; w_int <= '0;
      w_last  <= '0; w_div <= '0; err_q <= '0;
      w_mode  <= MODE_POSITION;
      pterm_q <= '0;
      iprod_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        integral_q[i]  <= '0;
        last_err_q[i]  <= '0;
        duty_q[i]      <= '0;
        prev_mode_q[i] <= MODE_POSITION;
      end
    end else begin
      case (state_q)
        ST_LOAD: begin
          w_kp   <= kp_q[ch_q];
          w_ki   <= ki_q[ch_q];
          w_kd   <= kd_q[ch_q];
          w_sp   <= sp_q[ch_q];
          w_opm  <= opm_q[ch_q];
          w_onm  <= onm_q[ch_q];
          w_ipm  <= ipm_q[ch_q];
          w_inm  <= inm_q[ch_q];
          w_db   <= db_q[ch_q];
          w_zs   <= zs_q[ch_q];
          w_mode <= mode_q[ch_q];
          w_div  <= div_q[ch_q];
          w_fb   <= (mode_q[ch_q] == MODE_VELOCITY) ? vel_arr[ch_q] : pos_arr[ch_q];
          // A mode change since the last sweep starts the loop from a clean history.
          if (mode_q[ch_q] != prev_mode_q[ch_q]) begin
            w_int  <= '0;
            w_last <= '0;
          end else begin
            w_int  <= integral_q[ch_q];
            w_last <= last_err_q[ch_q];
          end
        end
        ST_ERR:   err_q   <= DATA_W'(sat(SAT_W'(diff_sh), DATA_W));
        ST_MUL_I: pterm_q <= product;
        ST_MUL_D: iprod_q <= product;
        ST_OUT: begin
          duty_q[ch_q]      <= out_duty;
          integral_q[ch_q]  <= out_int;
          last_err_q[ch_q]  <= out_last;
          prev_mode_q[ch_q] <= w_mode;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_msj_pid_controller_mc.sv
// tb/tb_msj_pid_controller_mc.sv - directed self-checking bench for msj_pid_controller_mc
module tb_msj_pid_controller_mc;
  import msj_pid_pkg::*;

  localparam int NUM_CH = 6;
  localparam int DATA_W = 32;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     cfg_write;
  logic [2:0]               cfg_channel;
  logic [3:0]               cfg_addr;
  logic [DATA_W-1:0]        cfg_writedata;
  logic [NUM_CH*DATA_W-1:0] position;
  logic [NUM_CH*DATA_W-1:0] velocity;
  logic                     update_controller;
  logic [NUM_CH*DATA_W-1:0] duty;
  logic                     busy;
  logic                     done;

  logic signed [DATA_W-1:0] pos_v[NUM_CH];
  logic signed [DATA_W-1:0] vel_v[NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fb
    assign position[g*DATA_W +: DATA_W] = pos_v[g];
    assign velocity[g*DATA_W +: DATA_W] = vel_v[g];
  end

  msj_pid_controller_mc #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
    .clock             (clock),
    .reset             (reset),
    .cfg_write         (cfg_write),
    .cfg_channel       (cfg_channel),
    .cfg_addr          (cfg_addr),
    .cfg_writedata     (cfg_writedata),
    .position          (position),
    .velocity          (velocity),
    .update_controller (update_controller),
    .duty              (duty),
    .busy              (busy),
    .done              (done)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_n;
  int done_n;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint duty_of(input int ch);
    logic signed [DATA_W-1:0] d;
    d = duty[ch*DATA_W +: DATA_W];
    return longint'(d);
  endfunction

  task automatic cfg(input int ch, input logic [3:0] addr, input int data);
    @(negedge clock);
    cfg_write     = 1'b1;
    cfg_channel   = 3'(ch);
    cfg_addr      = addr;
    cfg_writedata = data;
    @(negedge clock);
    cfg_write     = 1'b0;
  endtask

  task automatic limits(input int ch, input int opm, input int onm, input int ipm, input int inm);
    cfg(ch, CFG_OUT_POS_MAX, opm);
    cfg(ch, CFG_OUT_NEG_MAX, onm);
    cfg(ch, CFG_INT_POS_MAX, ipm);
    cfg(ch, CFG_INT_NEG_MAX, inm);
  endtask

  // One rising edge on update_controller, then wait (bounded) for done.
  task automatic sweep();
    bit seen;
    seen   = 1'b0;
    busy_n = 0;
    @(negedge clock);
    update_controller = 1'b1;
    @(negedge clock);
    update_controller = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (busy) busy_n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("sweep_done", longint'(seen), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset             = 1'b1;
    cfg_write         = 1'b0;
    cfg_channel       = '0;
    cfg_addr          = '0;
    cfg_writedata     = '0;
    update_controller = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      pos_v[i] = '0;
      vel_v[i] = '0;
    end
    repeat (3) @(negedge clock);
    check_eq("reset_busy", longint'(busy), 0);
    check_eq("reset_done", longint'(done), 0);
    for (int i = 0; i < NUM_CH; i++) check_eq($sformatf("reset_duty%0d", i), duty_of(i), 0);
    reset = 1'b0;

    // Position mode, proportional only: err=60, duty=120
    cfg(0, CFG_KP, 2);
    cfg(0, CFG_SP, 100);
    limits(0, 1000, -1000, 0, 0);
    pos_v[0] = 40;
    sweep();
    check_eq("pos_duty0", duty_of(0), 120);
    check_eq("sweep_busy_cycles", busy_n, 6*NUM_CH);

    // Integral with clamp: integral 10,15,15 -> duty 20,25,25
    cfg(1, CFG_KP, 1);
    cfg(1, CFG_KI, 1);
    cfg(1, CFG_SP, 10);
    limits(1, 1000, -1000, 15, -15);
    sweep();
    check_eq("int_sweep1", duty_of(1), 20);
    sweep();
    check_eq("int_sweep2", duty_of(1), 25);
    sweep();
    check_eq("int_sweep3", duty_of(1), 25);

    // Anti-windup: pterm outside output range holds integral
    cfg(2, CFG_KP, 100);
    cfg(2, CFG_KI, 1);
    cfg(2, CFG_SP, 20);
    limits(2, 500, -500, 1000, -1000);
    sweep();
    check_eq("windup_pos1", duty_of(2), 500);
    sweep();
    check_eq("windup_pos2", duty_of(2), 500);
    cfg(2, CFG_KP, 0);
    sweep();
    check_eq("windup_held", duty_of(2), 20);
    cfg(2, CFG_KP, 100);
    cfg(2, CFG_SP, -20);
    sweep();
    check_eq("windup_neg", duty_of(2), -500);

    // Derivative: 3*(10-0)=30, then 3*(10-10)=0
    cfg(3, CFG_KD, 3);
    cfg(3, CFG_SP, 10);
    limits(3, 1000, -1000, 0, 0);
    sweep();
    check_eq("deriv_first", duty_of(3), 30);
    sweep();
    check_eq("deriv_second", duty_of(3), 0);

    // Deadband, direct, off, misordered limits
    cfg(4, CFG_KP, 50);
    cfg(4, CFG_SP, 4);
    cfg(4, CFG_DEAD_BAND, 5);
    cfg(4, CFG_ZERO_SPEED, 7);
    limits(4, 1000, -1000, 0, 0);
    sweep();
    check_eq("deadband", duty_of(4), 7);
    cfg(4, CFG_CONTROL_MODE, 2);
    cfg(4, CFG_SP, -33);
    sweep();
    check_eq("direct_mode", duty_of(4), -33);
    cfg(4, CFG_CONTROL_MODE, 3);
    sweep();
    check_eq("off_mode", duty_of(4), 0);
    cfg(4, CFG_CONTROL_MODE, 0);
    cfg(4, CFG_KP, 0);
    cfg(4, CFG_SP, 0);
    cfg(4, CFG_ZERO_SPEED, 0);
    cfg(4, CFG_DEAD_BAND, 0);
    limits(4, 20, 50, 0, 0);
    sweep();
    check_eq("misordered_limits", duty_of(4), 20);

    // Integral cleared on mode change; velocity feedback used
    cfg(5, CFG_KI, 1);
    cfg(5, CFG_SP, 10);
    limits(5, 1000, -1000, 1000, -1000);
    sweep();
    check_eq("mode_int1", duty_of(5), 10);
    sweep();
    check_eq("mode_int2", duty_of(5), 20);
    cfg(5, CFG_CONTROL_MODE, 1);
    vel_v[5] = 4;
    sweep();
    check_eq("mode_change_clear", duty_of(5), 6);

    // Divider: diff=-9 >>> 3 = -2; write to channel 6 must be ignored
    cfg(0, CFG_KP, 1);
    cfg(0, CFG_SP, 0);
    cfg(0, CFG_OUTPUT_DIVIDER, 3);
    cfg(6, CFG_KP, 100);
    cfg(6, CFG_SP, 100);
    pos_v[0] = 9;
    sweep();
    check_eq("divider", duty_of(0), -2);

    // Extreme operands saturate without wrap
    cfg(3, CFG_KD, 0);
    cfg(3, CFG_KP, 32'h7FFFFFFF);
    cfg(3, CFG_SP, 32'h7FFFFFFF);
    pos_v[3] = 32'sh80000000;
    sweep();
    check_eq("extreme_pos", duty_of(3), 1000);
    cfg(3, CFG_SP, 32'h80000000);
    pos_v[3] = 32'sh7FFFFFFF;
    sweep();
    check_eq("extreme_neg", duty_of(3), -1000);

    // Two rises during one sweep -> exactly one extra sweep
    busy_n = 0;
    done_n = 0;
    @(negedge clock);
    update_controller = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clock);
      case (i)
        0, 7, 11: update_controller = 1'b0;
        5, 9:     update_controller = 1'b1;
        default: ;
      endcase
      if (busy) busy_n++;
      if (done) done_n++;
    end
    check_eq("pending_done_pulses", done_n, 2);
    check_eq("pending_busy_cycles", busy_n, 12*NUM_CH);

    // Reset mid-sweep aborts with no done and clears duty
    done_n = 0;
    @(negedge clock);
    update_controller = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (i == 0)  update_controller = 1'b0;
      if (i == 10) reset = 1'b1;
      if (i == 12) reset = 1'b0;
      if (done) done_n++;
    end
    check_eq("abort_no_done", done_n, 0);
    check_eq("abort_busy", longint'(busy), 0);
    for (int i = 0; i < NUM_CH; i++) check_eq($sformatf("abort_duty%0d", i), duty_of(i), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
